// File: rtl/demux_2_output_2bit_reg.sv
// Registered 1-to-2 demultiplexer: routes one valid/ready source stream into two
// one-entry output registers, chosen by S or by an alternating toggle.
module demux_2_output_2bit_reg #(
   parameter int DATA_W = 2,
   parameter int CNT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] In_data,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic              S,
   input  logic              Mode,
   output logic [DATA_W-1:0] Out_1,
   output logic              Out_1_valid,
   input  logic              Out_1_ready,
   output logic [DATA_W-1:0] Out_2,
   output logic              Out_2_valid,
   input  logic              Out_2_ready,
   output logic [CNT_W-1:0]  Count_1,
   output logic [CNT_W-1:0]  Count_2,
   output logic              Toggle_state
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] out1_q, out1_d;
   logic [DATA_W-1:0] out2_q, out2_d;
   logic              out1_valid_q, out1_valid_d;
   logic              out2_valid_q, out2_valid_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;
   logic [CNT_W-1:0]  cnt2_q, cnt2_d;
   logic              toggle_q, toggle_d;

   logic target_s;
   logic free1_s;
   logic free2_s;
   logic in_ready_s;
   logic accept_s;
   logic acc1_s;
   logic acc2_s;

   // A slot can take a word when it is empty or is being drained this cycle.
   function automatic logic slot_free(input logic valid, input logic ready);
      return (~valid) | ready;
   endfunction

   // Route selection and acceptance; In_ready never looks at In_valid.
   always_comb begin
      target_s   = Mode ? toggle_q : S;
      free1_s    = slot_free(out1_valid_q, Out_1_ready);
      free2_s    = slot_free(out2_valid_q, Out_2_ready);
      in_ready_s = target_s ? free2_s : free1_s;
      accept_s   = In_valid & in_ready_s;
      acc1_s     = accept_s & ~target_s;
      acc2_s     = accept_s & target_s;
   end

   // Slot 1 next state: refill wins over drain; a drain keeps the stale data.
   always_comb begin
      out1_d       = out1_q;
      out1_valid_d = out1_valid_q;
      cnt1_d       = cnt1_q;
      if (acc1_s) begin
         out1_d       = In_data;
         out1_valid_d = 1'b1;
         cnt1_d       = cnt1_q + CNT_ONE;
      end else if (out1_valid_q & Out_1_ready) begin
         out1_valid_d = 1'b0;
      end else begin
         out1_valid_d = out1_valid_q;
      end
   end

   // Slot 2 next state, same rules as slot 1.
   always_comb begin
      out2_d       = out2_q;
      out2_valid_d = out2_valid_q;
      cnt2_d       = cnt2_q;
      if (acc2_s) begin
         out2_d       = In_data;
         out2_valid_d = 1'b1;
         cnt2_d       = cnt2_q + CNT_ONE;
      end else if (out2_valid_q & Out_2_ready) begin
         out2_valid_d = 1'b0;
      end else begin
         out2_valid_d = out2_valid_q;
      end
   end

   // The toggle only advances on an accepted word in alternating mode, so a
   // blocked target never lets the stream skip to the other slot.
   always_comb begin
      toggle_d = toggle_q;
      if (Mode & accept_s) begin
         toggle_d = ~toggle_q;
      end else begin
         toggle_d = toggle_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out1_q       <= {DATA_W{1'b0}};
         out2_q       <= {DATA_W{1'b0}};
         out1_valid_q <= 1'b0;
         out2_valid_q <= 1'b0;
         cnt1_q       <= {CNT_W{1'b0}};
         cnt2_q       <= {CNT_W{1'b0}};
         toggle_q     <= 1'b0;
      end else begin
         out1_q       <= out1_d;
         out2_q       <= out2_d;
         out1_valid_q <= out1_valid_d;
         out2_valid_q <= out2_valid_d;
         cnt1_q       <= cnt1_d;
         cnt2_q       <= cnt2_d;
         toggle_q     <= toggle_d;
      end
   end

   assign In_ready     = in_ready_s;
   assign Out_1        = out1_q;
   assign Out_1_valid  = out1_valid_q;
   assign Out_2        = out2_q;
   assign Out_2_valid  = out2_valid_q;
   assign Count_1      = cnt1_q;
   assign Count_2      = cnt2_q;
   assign Toggle_state = toggle_q;

endmodule

// File: doc/demux_2_output_2bit_reg.md
Name: demux_2_output_2bit_reg

Overview:
Registered 1-to-2 demultiplexer for 2-bit data. It is the distribution-side counterpart of the team's 2-input 2-bit selector: one source stream is routed to one of two destinations. Routing comes from an explicit select (S) or from an internal alternating toggle. Each destination has a one-entry output register with a valid/ready handshake and a per-output transfer counter.

Parameters:
DATA_W, 2, width of data path
CNT_W, 4, width of each per-output transfer counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
In_data  input  DATA_W  source data
In_valid  input  1  source data valid
In_ready  output  1  block can accept In_data this cycle
S  input  1  manual route select: 0 -> Out_1, 1 -> Out_2 (used when Mode=0)
Mode  input  1  0 = manual (S), 1 = alternating (internal toggle)
Out_1  output  DATA_W  destination 1 data (registered)
Out_1_valid  output  1  Out_1 holds data
Out_1_ready  input  1  destination 1 accepts Out_1
Out_2  output  DATA_W  destination 2 data (registered)
Out_2_valid  output  1  Out_2 holds data
Out_2_ready  input  1  destination 2 accepts Out_2
Count_1  output  CNT_W  number of words accepted for Out_1, modulo 2^CNT_W
Count_2  output  CNT_W  number of words accepted for Out_2, modulo 2^CNT_W
Toggle_state  output  1  current alternating target: 0 -> Out_1, 1 -> Out_2

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- On RST: Out_1, Out_2 = 0; Out_1_valid, Out_2_valid = 0; Count_1, Count_2 = 0; Toggle_state = 0. In_ready follows combinationally, so it reads 1 during reset.
- Target (combinational): target = Mode ? Toggle_state : S.
- Slot x is free when Out_x_valid = 0, or when Out_x_valid & Out_x_ready are both 1 in the same cycle (drain and refill).
- In_ready = free(target). In_ready depends on S, Mode and Toggle_state. It must not depend on In_valid.
- Accept: occurs when In_valid & In_ready at a rising CLK edge. Out_target <= In_data, Out_target_valid <= 1, Count_target <= Count_target + 1 (wraps from 2^CNT_W-1 to 0).
- Latency: data accepted at edge N is visible on Out_x after edge N (1 cycle).
- Drain: Out_x_valid & Out_x_ready with no refill of x at the same edge -> Out_x_valid <= 0. Out_x keeps its last value; it is not cleared.
- Hold: while Out_x_valid=1 and Out_x_ready=0, Out_x and Out_x_valid must stay stable.
- The non-target slot is unaffected by an accept. It can still drain in the same cycle, independently.
- Toggle: in Mode=1, Toggle_state inverts on every accept. In Mode=0 it holds its value.
- Mode change: takes effect combinationally on the next cycle's target. Toggle_state is retained across mode switches.
- Blocking: if the target slot is full and not draining, In_ready=0 and nothing is accepted. In Mode=1 the toggle does not advance, so there is no skipping to the free slot.
- Simultaneous: accept into x plus drain of x at the same edge -> the new word is loaded and valid stays 1. The count increments once.
- Counters count accepts, not drains.
- RST asserted mid-transfer: all state clears immediately (asynchronous). Pending output words are discarded.

Test Plan:
- Reset/idle: assert RST with Out_x_ready=0 -> all outputs 0, In_ready=1, Toggle_state=0. Release RST with In_valid=0 -> state unchanged for 5 cycles.
- Manual routing: Mode=0, S=0, In_data=2'b10, In_valid=1 for 1 cycle, both ready=1 -> next cycle Out_1=2'b10, Out_1_valid=1, Count_1=1. Then S=1, In_data=2'b01 -> Out_2=2'b01, Count_2=1; Out_1_valid drops to 0.
- Alternating: Mode=1, stream 3,2,1,0 back-to-back with both ready=1 -> Out_1 receives 3 then 1, Out_2 receives 2 then 0. Toggle_state sequence 0,1,0,1,0. Count_1=2, Count_2=2.
- Back-pressure: Mode=0, S=0, Out_1_ready=0, send 2'b11 then 2'b00 -> In_ready=0 after the first accept and Out_1 holds 2'b11. Raise Out_1_ready -> 2'b00 loads at the same edge the drain occurs; Out_1_valid stays 1 and Count_1=2.
- Counter wrap: 16 accepts to Out_2 (CNT_W=4) -> Count_2 goes 15 -> 0; Count_1 remains 0.
- Async reset mid-stream: Out_1_valid=1, Count_1=5, Toggle_state=1; pulse RST between clock edges -> all outputs 0 immediately, without waiting for CLK.
